// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i multi-cycle control path: FSM states, opcodes,
// ALU operation codes and datapath mux select encodings.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTER = 4'd6,
    ST_EXECUTEI = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR_ADR = 4'd11,
    ST_JALR_PC  = 4'd12,
    ST_LUI      = 4'd13,
    ST_AUIPC    = 4'd14,
    ST_TRAP     = 4'd15
  } estado_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_ALUOUT    = 1'b1;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRC_A_PC      = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC   = 2'b01;
  localparam logic [1:0] SRC_A_RS1     = 2'b10;
  localparam logic [1:0] SRC_A_ZERO    = 2'b11;
  localparam logic [1:0] SRC_B_RS2     = 2'b00;
  localparam logic [1:0] SRC_B_IMM     = 2'b01;
  localparam logic [1:0] SRC_B_FOUR    = 2'b10;

  // Successor of DECODE; ST_TRAP marks an opcode the core does not implement.
  function automatic estado_t destino_decode(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: destino_decode = ST_MEMADR;
      OP_RTYPE:          destino_decode = ST_EXECUTER;
      OP_ITYPE:          destino_decode = ST_EXECUTEI;
      OP_BRANCH:         destino_decode = ST_BRANCH;
      OP_JAL:            destino_decode = ST_JAL;
      OP_JALR:           destino_decode = ST_JALR_ADR;
      OP_LUI:            destino_decode = ST_LUI;
      OP_AUIPC:          destino_decode = ST_AUIPC;
      default:           destino_decode = ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/unidad_control_multiciclo_decodificador_alu.sv
// ALU control decoder: maps the FSM's ALU request plus funct3/funct7b5 to the
// ALU operation code.
module decodificador_alu
  import rv32i_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [6:0] opcode,
  output logic [3:0] alu_control
);

  logic es_resta;

  // ADDI has no SUB form, so funct7b5 only selects SUB for register operands.
  assign es_resta = funct7b5 && (opcode == OP_RTYPE);

  // Operation selection
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = es_resta ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle rv32i control FSM. Define CONTROL_TRAP_EN to trap illegal opcodes
// (adds the excepcion port); otherwise they retire as a NOP from DECODE.
module unidad_control_multiciclo
  import rv32i_pkg::*;
#(
  parameter int ANCHO_ESTADO = 4
) (
  input  logic                    clk_RV,
  input  logic                    reset,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic                    funct7b5,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    ir_write,
  output logic                    adr_src,
  output logic                    mem_write,
  output logic                    reg_write,
  output logic [1:0]              result_src,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [3:0]              alu_control,
  output logic                    instr_done,
  output logic [ANCHO_ESTADO-1:0] estado
`ifdef CONTROL_TRAP_EN
  ,
  output logic                    excepcion
`endif
);

  estado_t state;
  estado_t destino;
  alu_op_t alu_op;
  logic    salto;

  assign destino = destino_decode(opcode);
  assign salto   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
  assign estado  = ANCHO_ESTADO'(state);
`ifdef CONTROL_TRAP_EN
  assign excepcion = (state == ST_TRAP);
`endif

  // State sequencing
  always_ff @(posedge clk_RV or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:    state <= mem_ready ? ST_DECODE : ST_FETCH;
`ifdef CONTROL_TRAP_EN
        ST_DECODE:   state <= destino;
        ST_TRAP:     state <= ST_TRAP;
`else
        ST_DECODE:   state <= (destino == ST_TRAP) ? ST_FETCH : destino;
        ST_TRAP:     state <= ST_FETCH;
`endif
        ST_MEMADR:   state <= (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
        ST_MEMREAD:  state <= mem_ready ? ST_MEMWB : ST_MEMREAD;
        ST_MEMWRITE: state <= mem_ready ? ST_FETCH : ST_MEMWRITE;
        ST_EXECUTER, ST_EXECUTEI, ST_JAL, ST_JALR_PC, ST_LUI, ST_AUIPC:
                     state <= ST_ALUWB;
        ST_JALR_ADR: state <= ST_JALR_PC;
        default:     state <= ST_FETCH;
      endcase
    end
  end

  // Datapath controls; reset forces every enable low regardless of state.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = ADR_PC;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
    if (reset) begin
      alu_src_b  = SRC_B_FOUR;
      result_src = RES_ALURESULT;
    end else begin
      case (state)
        ST_FETCH: begin
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALURESULT;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        ST_DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
`ifndef CONTROL_TRAP_EN
          instr_done = (destino == ST_TRAP);
`endif
        end
        ST_MEMADR, ST_JALR_ADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        ST_MEMREAD: adr_src = ADR_ALUOUT;
        ST_MEMWB: begin
          result_src = RES_MEMDATA;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        ST_MEMWRITE: begin
          adr_src    = ADR_ALUOUT;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        ST_EXECUTER: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALUOP_FUNCT;
        end
        ST_EXECUTEI: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALUOP_FUNCT;
        end
        ST_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a  = SRC_A_RS1;
          alu_op     = ALUOP_SUB;
          pc_write   = salto;
          instr_done = 1'b1;
        end
        ST_JAL, ST_JALR_PC: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_FOUR;
          pc_write  = 1'b1;
        end
        ST_LUI: begin
          alu_src_a = SRC_A_ZERO;
          alu_src_b = SRC_B_IMM;
        end
        ST_AUIPC: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
        end
        default: alu_op = ALUOP_ADD;
      endcase
    end
  end

  decodificador_alu u_decodificador_alu (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .opcode      (opcode),
    .alu_control (alu_control)
  );

endmodule

// File: doc/unidad_control_multiciclo.md
Name: unidad_control_multiciclo

Overview:
- Multi-cycle control FSM that sequences the rv32i datapath: PC, instruction register, ALU, register file and a shared instruction/data memory.
- Moves the processor from single-cycle to multi-cycle operation.
- Decodes the latched instruction fields and drives all datapath selects and write enables.
- Stalls on a memory ready handshake; pulses a retire strobe per completed instruction.

Parameters:
- ANCHO_ESTADO, 4, width of state register/debug port.

Ports:
- clk_RV  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  instruction[6:0] from IR.
- funct3  in  3  instruction[14:12].
- funct7b5  in  1  instruction[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR and oldPC load enable.
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result direct.
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero.
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- alu_control  out  4  ALU operation code.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- estado  out  ANCHO_ESTADO  current state, for debug.

Behaviour:
- Single clock clk_RV; reset is asynchronous and active-high. Reset drives state to FETCH.
- All enables (pc_write, ir_write, mem_write, reg_write, instr_done) are 0 while reset is high.
- Outputs are combinational from state and inputs (Moore, plus zero/mem_ready gating).
- States and actions; every state not listed as waiting advances in one cycle:
  - FETCH: adr_src=0, a=00, b=10, ADD, result_src=10. ir_write and pc_write equal mem_ready. Stays while mem_ready=0; when mem_ready=1 goes to DECODE.
  - DECODE: a=01, b=01, ADD (branch/JAL target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR_ADR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - any other -> illegal handling (see Optional Feature).
  - MEMADR: a=10, b=01, ADD. Load -> MEMREAD; store -> MEMWRITE.
  - MEMREAD: adr_src=1; waits for mem_ready, then MEMWB.
  - MEMWB: result_src=01, reg_write=1, instr_done=1 -> FETCH.
  - MEMWRITE: adr_src=1, mem_write=1 held until mem_ready. instr_done=mem_ready. -> FETCH when mem_ready.
  - EXECUTER: a=10, b=00, ALU op from funct3/funct7b5 -> ALUWB.
  - EXECUTEI: a=10, b=01, same decode except funct7b5 is ignored for funct3=000 -> ALUWB.
  - ALUWB: result_src=00, reg_write=1, instr_done=1 -> FETCH.
  - BRANCH: a=10, b=00, SUB, result_src=00. pc_write=1 when (funct3=000 and zero) or (funct3=001 and not zero). instr_done=1 -> FETCH.
  - JAL: a=01, b=10, ADD, result_src=00, pc_write=1 -> ALUWB.
  - JALR_ADR: a=10, b=01, ADD -> JALR_PC.
  - JALR_PC: a=01, b=10, ADD, result_src=00, pc_write=1 -> ALUWB.
  - LUI: a=11, b=01, ADD -> ALUWB.
  - AUIPC: a=01, b=01, ADD -> ALUWB.
- ALU decode by funct3:
  - 000: ADD, or SUB when R-type and funct7b5=1
  - 001: SLL
  - 010: SLT
  - 100: XOR
  - 101: SRL, or SRA when funct7b5=1
  - 110: OR
  - 111: AND
- Latency with mem_ready=1:
  - R/I/LUI/AUIPC/JAL/store: 4 cycles
  - load and JALR: 5 cycles
  - branch: 3 cycles
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset mid-instruction aborts immediately to FETCH; no partial write is issued.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Optional Feature:
- Macro CONTROL_TRAP_EN.
- Defined: an illegal opcode in DECODE enters TRAP. TRAP holds output excepcion=1 and drives all enables to 0. It stays in TRAP until reset.
- Undefined: an illegal opcode is treated as a NOP. DECODE pulses instr_done and returns to FETCH. The excepcion port does not exist.

Decomposition:
- Shared package rv32i_pkg holds:
  - state encodings
  - opcode constants
  - ALU control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000
  - mux select encodings
- One sub-module, decodificador_alu: combinational mapping of alu_op/funct3/funct7b5/opcode to alu_control.

Test Plan:
- R-type SUB (opcode 0110011, funct3 000, funct7b5 1), mem_ready=1: states FETCH, DECODE, EXECUTER, ALUWB. alu_control=0001 in EXECUTER; reg_write and instr_done in cycle 4 only.
- Load with mem_ready low 3 cycles in MEMREAD: stays 4 cycles in MEMREAD, adr_src=1 throughout. reg_write only in MEMWB (result_src=01); total 8 cycles.
- Branch funct3 000:
  - zero=1: pc_write=1 in BRANCH.
  - funct3 001 with zero=1: pc_write=0. Both take 3 cycles.
- Reset asserted asynchronously during MEMWRITE with mem_ready=0: mem_write drops to 0 the same instant; estado=FETCH after release.
- Illegal opcode 1111111:
  - with CONTROL_TRAP_EN: excepcion=1 held, no further ir_write.
  - without: instr_done in DECODE, then FETCH.
- JALR: 5 cycles. pc_write in JALR_PC with result_src=00; reg_write in ALUWB.
